// File: rtl/mul_ctrl_pkg.sv
// rtl/mul_ctrl_pkg.sv - shared types and constants for the border multiplier controller
// Purpose: controller state encoding, default widths and the RUN watchdog limit.
// Ports: none (package).
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } mul_ctrl_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ACC_W = 16;

  // Longest legal RUN phase in cycles for a given datapath width; one more
  // RUN cycle than this means the cell's activation stream is stuck.
  function automatic int wdog_limit(input int width);
    return 2 ** (width - 1);
  endfunction

endpackage

// File: rtl/sat_acc_inc.sv
// rtl/sat_acc_inc.sv - saturating unit-increment accumulator with sticky saturation flag
// Purpose: counts product bits for one dot-product group, clamping at all-ones.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr           clear acc and sat (highest priority)
//   inc           add one to acc
//   sat_set       force the sticky saturation flag
//   acc [ACC_W]   accumulated value
//   sat           set once an increment was lost or sat_set was seen
module sat_acc_inc
  import mul_ctrl_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             sat_set,
  output logic [ACC_W-1:0] acc,
  output logic             sat
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else begin
      if (inc) begin
        if (&acc) begin
          sat <= 1'b1;
        end else begin
          acc <= acc + 1'b1;
        end
      end
      if (sat_set) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_border_ctrl.sv
// rtl/mul_border_ctrl.sv - sequencing controller for one unary-temporal border multiplier cell
// Purpose: accepts activation/weight pairs, loads them into the cell, counts product
//          bits during the activation stream and returns one saturated sum per group.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   in_valid/in_ready                 pair handshake; in_act, in_wgt, in_last pair data
//   abort                             synchronous cancel of the current group
//   mul_init, mul_clr                 load pulse and clear to the cell
//   mul_data_i, mul_data_w            operands to the cell
//   mul_o_bit, mul_i_bit_d            product bit and activation-active bit from the cell
//   out_valid/out_ready               result handshake; out_acc, out_sat result
module mul_border_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-2:0] in_act,
  input  logic [WIDTH-2:0] in_wgt,
  input  logic             in_last,
  input  logic             abort,
  output logic             mul_init,
  output logic             mul_clr,
  output logic [WIDTH-2:0] mul_data_i,
  output logic [WIDTH-2:0] mul_data_w,
  input  logic             mul_o_bit,
  input  logic             mul_i_bit_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat
);

  localparam int WDOG_CYCLES = wdog_limit(WIDTH);

  mul_ctrl_state_t  state_q, state_d;
  logic [WIDTH-2:0] act_q, wgt_q;
  logic             last_q;
  logic [WIDTH-1:0] run_cnt_q;
  logic             clr_q;
  logic             ready_q;

  logic accept, wdog_fire, pair_done, acc_inc, acc_clr;

  // ready_q keeps in_ready low while reset is held even though state is IDLE.
  assign in_ready  = ready_q && (state_q == IDLE);
  assign accept    = in_ready && in_valid && !abort;

  // run_cnt_q holds the number of RUN cycles already completed.
  assign wdog_fire = (state_q == RUN) && mul_i_bit_d && (run_cnt_q == WIDTH'(WDOG_CYCLES));
  assign pair_done = (state_q == RUN) && (!mul_i_bit_d || wdog_fire);

  assign acc_inc   = (state_q == RUN) && mul_i_bit_d && mul_o_bit && !wdog_fire;
  assign acc_clr   = abort || ((state_q == OUT) && out_ready);

  assign mul_init   = (state_q == LOAD);
  assign mul_data_i = (state_q == LOAD) ? act_q : '0;
  assign mul_data_w = wgt_q;
  assign mul_clr    = clr_q;
  assign out_valid  = (state_q == OUT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (pair_done) state_d = last_q ? OUT : IDLE;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      act_q     <= '0;
      wgt_q     <= '0;
      last_q    <= 1'b0;
      run_cnt_q <= '0;
      clr_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      clr_q   <= abort || wdog_fire;
      if (accept) begin
        act_q  <= in_act;
        wgt_q  <= in_wgt;
        last_q <= in_last;
      end
      if ((state_q == RUN) && !pair_done) begin
        run_cnt_q <= run_cnt_q + 1'b1;
      end else begin
        run_cnt_q <= '0;
      end
    end
  end

  sat_acc_inc #(
    .ACC_W(ACC_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .inc     (acc_inc),
    .sat_set (wdog_fire),
    .acc     (out_acc),
    .sat     (out_sat)
  );

endmodule
